probe_trace_buffer: RTL and testbench

//  Synthesizable, parametrised successor to the single-channel probe buffer blackbox.

---
 rtl/probe_trace_buffer.sv | 158 +++++++++++++++
 tb/tb_probe_trace_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/probe_trace_buffer.sv
// probe_trace_buffer
//   Captures tagged probe words from CHANNELS sources into a shared DEPTH-entry
//   buffer. The buffer either stops accepting words when full (FIFO) or replaces
//   the oldest entry (RING). Entries leave through a valid/ready drain port.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   wen         per-channel write strobe
//   write       channel c data at [c*WIDTH +: WIDTH]
//   mode        0 = FIFO (stop when full), 1 = RING (overwrite oldest)
//   freeze      ignore all wen (no capture, no drop counting); pops still allowed
//   clear       synchronous flush of buffer and status, highest priority
//   rd_ready    consumer accepts the head entry
//   rd_valid    head entry present
//   rd_data     head entry data (zero when empty)
//   rd_chan     head entry source channel (zero when empty)
//   count       occupied entries, 0..DEPTH
//   drop_count  saturating count of words lost to arbitration or FIFO-full
//   overflow    sticky flag, set by any RING overwrite
module probe_trace_buffer #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DROP_W   = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       wen,
  input  logic [CHANNELS*WIDTH-1:0] write,
  input  logic                      mode,
  input  logic                      freeze,
  input  logic                      clear,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CW-1:0]             rd_chan,
  output logic [NW-1:0]             count,
  output logic [DROP_W-1:0]         drop_count,
  output logic                      overflow
);

  localparam int EW = CW + WIDTH;
  localparam int RW = $clog2(CHANNELS + 1);

  // Storage is deliberately left out of reset so it maps onto RAM.
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     head_reg, head_next;
  logic [PW-1:0]     tail_reg, tail_next;
  logic [NW-1:0]     count_reg, count_next;
  logic [DROP_W-1:0] drop_reg, drop_next;
  logic              overflow_reg, overflow_next;

  logic [WIDTH-1:0]  lane_data [CHANNELS];
  logic              cand_found;
  logic [CW-1:0]     cand_chan;
  logic [WIDTH-1:0]  cand_data;
  logic [RW-1:0]     req_cnt;

  logic              capture, full, pop, fifo_reject, overwrite, push;
  logic [RW:0]       drop_inc;
  logic [DROP_W:0]   drop_sum;
  logic [EW-1:0]     head_entry;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    assign lane_data[gi] = write[gi*WIDTH +: WIDTH];
  end

  // Lowest asserted channel wins; every other asserted channel is a drop.
  always_comb begin
    cand_found = 1'b0;
    cand_chan  = '0;
    cand_data  = '0;
    req_cnt    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wen[i]) begin
        if (!cand_found) begin
          cand_found = 1'b1;
          cand_chan  = CW'(i);
          cand_data  = lane_data[i];
        end
        req_cnt = req_cnt + RW'(1);
      end
    end
  end

  // All decisions use the occupancy at the start of the cycle.
  always_comb begin
    capture     = !freeze && cand_found;
    full        = (count_reg == NW'(DEPTH));
    pop         = rd_valid && rd_ready;
    fifo_reject = capture && full && !pop && !mode;
    overwrite   = capture && full && !pop && mode;
    push        = capture && !fifo_reject;

    drop_inc = '0;
    if (capture) begin
      drop_inc = {1'b0, req_cnt - RW'(1)} + (RW+1)'(fifo_reject);
    end
    drop_sum  = {1'b0, drop_reg} + (DROP_W+1)'(drop_inc);
    drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    // An overwrite retires the oldest entry exactly like a pop would.
    head_next = head_reg + PW'(pop || overwrite);
    tail_next = tail_reg + PW'(push);

    count_next = count_reg;
    if (push && !pop && !overwrite) begin
      count_next = count_reg + NW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - NW'(1);
    end

    overflow_next = overflow_reg || overwrite;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      drop_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      drop_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      drop_reg     <= drop_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[tail_reg] <= {cand_chan, cand_data};
    end
  end

  // Head is read straight from storage; outputs are forced to zero when empty
  // so that nothing stale is visible out of reset.
  assign head_entry = mem[head_reg];
  assign rd_valid   = (count_reg != '0);
  assign rd_data    = rd_valid ? head_entry[WIDTH-1:0] : '0;
  assign rd_chan    = rd_valid ? head_entry[EW-1:WIDTH] : '0;
  assign count      = count_reg;
  assign drop_count = drop_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_probe_trace_buffer.sv
module tb_probe_trace_buffer;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [3:0]        wen = '0;
  logic [255:0]      write = '0;
  logic              mode = 1'b0;
  logic              freeze = 1'b0;
  logic              clear = 1'b0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [63:0]       rd_data;
  logic [1:0]        rd_chan;
  logic [4:0]        count;
  logic [15:0]       drop_count;
  logic              overflow;

  int errors = 0;
  int checks = 0;

  probe_trace_buffer #(.WIDTH(64), .DEPTH(16), .CHANNELS(4), .DROP_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .wen(wen), .write(write), .mode(mode),
    .freeze(freeze), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_chan(rd_chan), .count(count),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]       wen;
    logic [3:0][63:0] d;
    logic             rdy;
    logic             clr;
    logic [4:0]       e_cnt;
    logic             e_valid;
    logic [63:0]      e_data;
    logic [1:0]       e_chan;
    logic [15:0]      e_drop;
    logic             e_ovf;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [3:0] w, input logic [63:0] d0, d1, d2, d3,
                              input logic rdy, clr, input logic [4:0] c, input logic v,
                              input logic [63:0] dat, input logic [1:0] ch,
                              input logic [15:0] dr, input logic ov);
    vec_t r;
    r.wen = w; r.d = {d3, d2, d1, d0}; r.rdy = rdy; r.clr = clr;
    r.e_cnt = c; r.e_valid = v; r.e_data = dat; r.e_chan = ch; r.e_drop = dr; r.e_ovf = ov;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock transaction: inputs applied 1 time unit after an edge, state
  // observed 1 time unit after the following edge.
  task automatic step(input logic [3:0] w, input logic [3:0][63:0] d, input logic rdy);
    wen = w; write = d; rd_ready = rdy;
    @(posedge clock);
    #1;
    $display("txn wen=%b rdy=%b mode=%b frz=%b clr=%b -> cnt=%0d v=%b data=%0h ch=%0d drop=%0d ovf=%b",
             w, rdy, mode, freeze, clear, count, rd_valid, rd_data, rd_chan, drop_count, overflow);
  endtask

  task automatic push1(input logic [1:0] ch, input logic [63:0] val, input logic rdy);
    logic [3:0][63:0] d;
    d = '0;
    d[ch] = val;
    step(4'b0001 << ch, d, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(4'b0000, '0, rdy);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1'b0);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: five pushes on channel 0, then five pops.
    for (int i = 0; i < 5; i++)
      vecs[i] = mk(4'b0001, 64'(i + 1), 0, 0, 0, 0, 0, 5'(i + 1), 1, 64'd1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      vecs[5 + i] = mk(4'b0000, 0, 0, 0, 0, 1, 0, 5'(4 - i), (i < 4),
                       (i < 4) ? 64'(i + 2) : 64'd0, 0, 0, 0);
    // Test 2: channels 1..3 together; channel 1 wins, two drops.
    vecs[10] = mk(4'b1110, 0, 64'hA, 64'hB, 64'hC, 0, 0, 1, 1, 64'hA, 1, 2, 0);
    // clear beats a simultaneous push.
    vecs[11] = mk(4'b0001, 64'h77, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Push into empty with rd_ready high: no bypass pop.
    vecs[12] = mk(4'b0001, 64'h55, 0, 0, 0, 1, 0, 1, 1, 64'h55, 0, 0, 0);
    vecs[13] = mk(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    #3;
    chk("reset_count", 64'(count), 0);
    chk("reset_valid", 64'(rd_valid), 0);
    chk("reset_data", rd_data, 0);
    chk("reset_chan", 64'(rd_chan), 0);
    chk("reset_drop", 64'(drop_count), 0);
    chk("reset_ovf", 64'(overflow), 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 14; i++) begin
      clear = vecs[i].clr;
      step(vecs[i].wen, vecs[i].d, vecs[i].rdy);
      clear = 1'b0;
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), rd_data, vecs[i].e_data);
      chk($sformatf("vec%0d_chan", i), 64'(rd_chan), 64'(vecs[i].e_chan));
      chk($sformatf("vec%0d_drop", i), 64'(drop_count), 64'(vecs[i].e_drop));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].e_ovf));
    end

    // Test 3: FIFO fill plus three rejected pushes.
    mode = 1'b0;
    for (int i = 0; i < 16; i++) push1(0, 64'(100 + i), 0);
    chk("fifo_fill_count", 64'(count), 16);
    for (int i = 0; i < 3; i++) push1(0, 64'(200 + i), 0);
    chk("fifo_full_count", 64'(count), 16);
    chk("fifo_full_drop", 64'(drop_count), 3);
    chk("fifo_full_ovf", 64'(overflow), 0);
    chk("fifo_full_head", rd_data, 100);
    // Test 5 (FIFO): full with simultaneous push and pop.
    push1(0, 64'd300, 1);
    chk("fifo_pp_count", 64'(count), 16);
    chk("fifo_pp_drop", 64'(drop_count), 3);
    chk("fifo_pp_head", rd_data, 101);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fifo_drain%0d", i), rd_data, (i < 15) ? 64'(101 + i) : 64'd300);
      idle(1);
    end
    chk("fifo_drained_valid", 64'(rd_valid), 0);

    // Test 4: RING, twenty pushes on channel 2.
    do_clear();
    chk("clear_drop", 64'(drop_count), 0);
    mode = 1'b1;
    for (int i = 0; i < 20; i++) push1(2, 64'(i), 0);
    chk("ring_count", 64'(count), 16);
    chk("ring_ovf", 64'(overflow), 1);
    chk("ring_drop", 64'(drop_count), 0);
    chk("ring_chan", 64'(rd_chan), 2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ring_drain%0d", i), rd_data, 64'(4 + i));
      idle(1);
    end
    chk("ring_drained_valid", 64'(rd_valid), 0);

    // Test 5 (RING): full push+pop, then overwrite, then switch to FIFO.
    do_clear();
    chk("clear_ovf", 64'(overflow), 0);
    for (int i = 0; i < 16; i++) push1(1, 64'(500 + i), 0);
    push1(1, 64'd600, 1);
    chk("ring_pp_count", 64'(count), 16);
    chk("ring_pp_head", rd_data, 501);
    chk("ring_pp_ovf", 64'(overflow), 0);
    chk("ring_pp_drop", 64'(drop_count), 0);
    push1(1, 64'd601, 0);
    chk("ring_ow_head", rd_data, 502);
    chk("ring_ow_ovf", 64'(overflow), 1);
    chk("ring_ow_count", 64'(count), 16);
    mode = 1'b0;
    push1(1, 64'd602, 0);
    chk("mode_sw_drop", 64'(drop_count), 1);
    chk("mode_sw_head", rd_data, 502);

    // Freeze: no capture or drops, but draining still works.
    do_clear();
    freeze = 1'b1;
    step(4'b1111, {64'd4, 64'd3, 64'd2, 64'd1}, 0);
    chk("freeze_count", 64'(count), 0);
    chk("freeze_drop", 64'(drop_count), 0);
    freeze = 1'b0;
    push1(0, 64'd7, 0);
    push1(0, 64'd8, 0);
    freeze = 1'b1;
    step(4'b1111, {64'd4, 64'd3, 64'd2, 64'd1}, 1);
    chk("freeze_pop_count", 64'(count), 1);
    chk("freeze_pop_data", rd_data, 8);
    chk("freeze_pop_drop", 64'(drop_count), 0);
    freeze = 1'b0;

    // Async reset in the middle of a drain.
    do_clear();
    for (int i = 0; i < 3; i++) step(4'b0011, {64'd0, 64'd0, 64'hEE, 64'(i + 1)}, 0);
    chk("pre_rst_drop", 64'(drop_count), 3);
    idle(1);
    chk("pre_rst_data", rd_data, 2);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", 64'(rd_valid), 0);
    chk("rst_data", rd_data, 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_ovf", 64'(overflow), 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_count", 64'(count), 0);
    push1(3, 64'h99, 0);
    chk("post_rst_push_count", 64'(count), 1);
    chk("post_rst_push_data", rd_data, 64'h99);
    chk("post_rst_push_chan", 64'(rd_chan), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
